// File: rtl/ss_result_packer.sv
// ss_result_packer: captures a burst of result words from the systolic core
// into a local buffer and replays it as a byte-serial frame (header byte with
// the word count, then every word little-endian) on a valid/ready port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for the first word of a burst
// COLLECT | storing burst words until in_valid drops
// HEADER  | presenting the word-count header byte
// DATA    | presenting buffered words byte by byte, LSB first
module ss_result_packer #(
   parameter int DW    = 40,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_value,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_data,
   output logic          out_last,
   output logic [AW:0]   burst_len,
   output logic          overflow
);

   localparam int NB = DW / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
   localparam logic [AW:0]   CNT_MAX   = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HEADER  = 2'd2,
      DATA    = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [AW:0]   cnt, cnt_nx;
   logic [AW-1:0] word_idx, word_nx;
   logic [BW-1:0] byte_idx, byte_nx;
   logic [DW-1:0] buf_mem [DEPTH];

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          ovf_set;
   logic          len_load;
   logic          hs;
   logic          last_word;
   logic [DW-1:0] shifted;

   assign hs        = out_valid & out_ready;
   assign last_word = ({1'b0, word_idx} == (cnt - 1'b1));

   // Next-state, counter and buffer-write control.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      word_nx  = word_idx;
      byte_nx  = byte_idx;
      wr_en    = 1'b0;
      wr_addr  = cnt[AW-1:0];
      ovf_set  = 1'b0;
      len_load = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               wr_en    = 1'b1;
               wr_addr  = '0;
               cnt_nx   = (AW + 1)'(1);
               state_nx = COLLECT;
            end
         end
         COLLECT: begin
            if (in_valid) begin
               if (cnt < CNT_MAX) begin
                  wr_en  = 1'b1;
                  cnt_nx = cnt + 1'b1;
               end else begin
                  ovf_set = 1'b1;
               end
            end else begin
               len_load = 1'b1;
               state_nx = HEADER;
            end
         end
         HEADER: begin
            ovf_set = in_valid;
            if (hs) begin
               state_nx = DATA;
               word_nx  = '0;
               byte_nx  = '0;
            end
         end
         DATA: begin
            ovf_set = in_valid;
            if (hs) begin
               if (last_word && (byte_idx == BYTE_LAST)) begin
                  state_nx = IDLE;
               end
               if (byte_idx == BYTE_LAST) begin
                  byte_nx = '0;
                  word_nx = word_idx + 1'b1;
               end else begin
                  byte_nx = byte_idx + 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, indices, latched burst length and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         word_idx  <= '0;
         byte_idx  <= '0;
         burst_len <= '0;
         overflow  <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         word_idx <= word_nx;
         byte_idx <= byte_nx;
         if (len_load) burst_len <= cnt;
         if (ovf_set)  overflow  <= 1'b1;
      end
   end

   // Burst word storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_en) buf_mem[wr_addr] <= in_value;
   end

   // Frame outputs derived only from registered state and indices.
   always_comb begin
      shifted   = buf_mem[word_idx] >> {byte_idx, 3'b000};
      out_valid = (state == HEADER) || (state == DATA);
      busy      = out_valid;
      out_last  = (state == DATA) && last_word && (byte_idx == BYTE_LAST);
      out_data  = 8'h00;
      if (state == HEADER)    out_data = 8'(cnt);
      else if (state == DATA) out_data = shifted[7:0];
   end

endmodule

// File: tb/tb_ss_result_packer.sv
// Bench for ss_result_packer: directed table of bursts, reset and busy-pulse
// corner sequences, then random bursts checked against a byte-frame model.
module tb_ss_result_packer;

   localparam int DW = 40;
   localparam int DEPTH = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_value = '0;
   logic          busy;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [7:0]    out_data;
   logic          out_last;
   logic [AW:0]   burst_len;
   logic          overflow;

   ss_result_packer #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_value(in_value),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .burst_len(burst_len),
      .overflow(overflow)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 1;
   logic [DW-1:0] wv [16];
   logic [8:0] cap [$];
   logic model_ovf = 1'b0;

   localparam int PAT_2X2 = 0;
   localparam int PAT_K   = 1;

   typedef struct {
      int   n;
      int   pat;
      int   mode;
      int   exp_len;
      logic exp_ovf;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_word();
      return DW'({$urandom(), $urandom()});
   endfunction

   // Consumer readiness: always ready or a 50% coin flip each cycle.
   initial forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
   end

   // Byte capture and stall-stability check at the falling edge.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data;
   logic       prev_last;
   initial forever begin
      @(negedge clk);
      if (rst_n && prev_stall) begin
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_data", 64'(out_data), 64'(prev_data));
         chk("stall_last", 64'(out_last), 64'(prev_last));
      end
      if (rst_n && out_valid && out_ready) cap.push_back({out_last, out_data});
      prev_stall = rst_n && out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
   end

   task automatic drive_burst(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_value = wv[i];
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_value = rnd_word();
   endtask

   task automatic check_frame(input int n);
      logic [8:0] exp [$];
      int m;
      m = (n > DEPTH) ? DEPTH : n;
      exp.push_back({1'b0, 8'(m)});
      for (int i = 0; i < m; i++)
         for (int b = 0; b < DW / 8; b++)
            exp.push_back({(i == m - 1) && (b == DW / 8 - 1), wv[i][8*b +: 8]});
      chk("frame_len", 64'(cap.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < cap.size(); i++)
         chk($sformatf("byte%0d", i), 64'(cap[i]), 64'(exp[i]));
   endtask

   // Full burst-to-frame transaction; pulse>0 injects in_valid while busy.
   task automatic do_burst(input int n, input int mode, input int pulse,
                           input int exp_len, input logic exp_ovf);
      int k;
      rdy_mode = mode;
      cap.delete();
      drive_burst(n);
      @(posedge clk);
      #1;
      chk("hdr_timing", 64'(out_valid), 64'd1);
      k = 0;
      while (busy && k < 500) begin
         in_valid = (pulse > 0) && (k == pulse);
         in_value = rnd_word();
         @(posedge clk);
         #1;
         k++;
      end
      in_valid = 1'b0;
      if (busy) chk("frame_timeout", 64'd1, 64'd0);
      if (mode != 0) chk("frame_cycles", 64'(k), 64'(1 + 5 * exp_len));
      check_frame(n);
      chk("burst_len", 64'(burst_len), 64'(exp_len));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
   endtask

   task automatic fill(input int pat, input int n);
      for (int i = 0; i < n; i++) begin
         if (pat == PAT_2X2) begin
            wv[i] = (i == 0) ? 40'h00_0000_0001 : (i == 1) ? 40'h12_3456_789A : 40'hFF_FFFF_FFFF;
         end else begin
            wv[i] = 40'(i + 1) * 40'h01_0101_0101;
         end
      end
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_valid"}, 64'(out_valid), 64'd0);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_data"}, 64'(out_data), 64'd0);
      chk({nm, "_last"}, 64'(out_last), 64'd0);
      chk({nm, "_len"}, 64'(burst_len), 64'd0);
      chk({nm, "_ovf"}, 64'(overflow), 64'd0);
   endtask

   vec_t tbl [4];

   initial begin
      int n, pulse, mode, m;
      tbl[0] = '{n: 3, pat: PAT_2X2, mode: 1, exp_len: 3, exp_ovf: 1'b0};
      tbl[1] = '{n: 7, pat: PAT_K,   mode: 1, exp_len: 7, exp_ovf: 1'b0};
      tbl[2] = '{n: 3, pat: PAT_2X2, mode: 0, exp_len: 3, exp_ovf: 1'b0};
      tbl[3] = '{n: 9, pat: PAT_K,   mode: 1, exp_len: 8, exp_ovf: 1'b1};

      #1;
      check_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_zero("post_reset");

      for (int t = 0; t < 4; t++) begin
         fill(tbl[t].pat, tbl[t].n);
         do_burst(tbl[t].n, tbl[t].mode, 0, tbl[t].exp_len, tbl[t].exp_ovf);
      end

      // Reset in the middle of the data bytes of a 2x2 frame.
      fill(PAT_2X2, 3);
      rdy_mode = 1;
      cap.delete();
      drive_burst(3);
      n = 0;
      while (cap.size() < 7 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("pre_reset_bytes", 64'(cap.size()), 64'd7);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("mid_reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cap.delete();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("idle_after_reset", 64'(out_valid), 64'd0);
      end
      chk("no_bytes_after_reset", 64'(cap.size()), 64'd0);
      model_ovf = 1'b0;
      fill(PAT_2X2, 3);
      do_burst(3, 1, 0, 3, 1'b0);

      // Core pulse while a frame is in flight, then a clean follow-up burst.
      fill(PAT_K, 3);
      do_burst(3, 1, 3, 3, 1'b1);
      model_ovf = 1'b1;
      fill(PAT_2X2, 3);
      do_burst(3, 0, 0, 3, 1'b1);

      // Random bursts and consumer behaviour against the frame model.
      reset_for_random();
      for (int r = 0; r < 16; r++) begin
         n = $urandom_range(1, 9);
         mode = $urandom_range(0, 1);
         pulse = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         for (int i = 0; i < n; i++) wv[i] = rnd_word();
         m = (n > DEPTH) ? DEPTH : n;
         if (n > DEPTH || pulse > 0) model_ovf = 1'b1;
         do_burst(n, mode, pulse, m, model_ovf);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   task automatic reset_for_random();
      rst_n = 1'b0;
      model_ovf = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rand_reset_ovf", 64'(overflow), 64'd0);
   endtask

endmodule
